// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU ops, mux selects and FSM states for the accumulator CPU control unit
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_JN    = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS_B = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;

    localparam logic PC_INC = 1'b0;
    localparam logic PC_IR  = 1'b1;
    localparam logic MAR_PC = 1'b0;
    localparam logic MAR_IR = 1'b1;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        FETCH_RD = 3'd1,
        DECODE   = 3'd2,
        MEM      = 3'd3,
        EXEC     = 3'd4,
        HALT     = 3'd5
    } state_t;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - counts stalled memory strobe cycles and flags when the wait limit is reached
module mem_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);

    logic [TW-1:0] count;

    // Any cycle without a stalled strobe zeroes the count, so each new access starts from 0.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (active && !ready)
            count <= count + 1'b1;
        else
            count <= '0;
    end

    assign expired = active && !ready && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multicycle fetch/decode/memory/execute sequencer for the 16-bit accumulator datapath
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           acc_zero,
    input  logic           acc_neg,
    input  logic           mem_ready,
    output logic           ld_pc,
    output logic           ld_ir,
    output logic           ld_acc,
    output logic           ld_mar,
    output logic           ld_mdr,
    output logic           pc_sel,
    output logic           mar_sel,
    output logic [2:0]     alu_op,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           halted,
    output logic           bus_error,
    output logic           illegal_op,
    output logic [2:0]     state_dbg
);

    state_t     state, state_n;
    logic       bus_err_q;
    logic       strobe, expired;
    logic [3:0] op;

    assign op     = 4'(opcode);
    assign strobe = (state == FETCH_RD) || (state == MEM);

    mem_watchdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .active  (strobe),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_n;
            if (expired)
                bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        ld_pc      = 1'b0;
        ld_ir      = 1'b0;
        ld_acc     = 1'b0;
        ld_mar     = 1'b0;
        ld_mdr     = 1'b0;
        pc_sel     = PC_INC;
        mar_sel    = MAR_PC;
        alu_op     = ALU_PASS_B;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        bus_error  = bus_err_q;
        state_dbg  = state;

        unique case (state)
            FETCH: begin
                mar_sel = MAR_PC;
                ld_mar  = 1'b1;
                state_n = FETCH_RD;
            end
            FETCH_RD: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ld_ir   = 1'b1;
                    ld_pc   = 1'b1;
                    pc_sel  = PC_INC;
                    state_n = DECODE;
                end else if (expired) begin
                    state_n = HALT;
                end
            end
            DECODE: begin
                state_n = FETCH;
                case (op)
                    OP_NOP: ;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: begin
                        mar_sel = MAR_IR;
                        ld_mar  = 1'b1;
                        state_n = MEM;
                    end
                    OP_JMP: begin
                        ld_pc  = 1'b1;
                        pc_sel = PC_IR;
                    end
                    OP_JZ: begin
                        ld_pc  = acc_zero;
                        pc_sel = PC_IR;
                    end
                    OP_JN: begin
                        ld_pc  = acc_neg;
                        pc_sel = PC_IR;
                    end
                    OP_HALT: state_n = HALT;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEM: begin
                if (op == OP_STORE)
                    mem_wr = 1'b1;
                else
                    mem_rd = 1'b1;
                if (mem_ready) begin
                    ld_mdr  = (op != OP_STORE);
                    state_n = (op == OP_STORE) ? FETCH : EXEC;
                end else if (expired) begin
                    state_n = HALT;
                end
            end
            EXEC: begin
                ld_acc  = 1'b1;
                state_n = FETCH;
                case (op)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_PASS_B;
                endcase
            end
            HALT: halted = 1'b1;
            default: state_n = FETCH;
        endcase

        // Reset silences every output in the same cycle, aborting any strobe in flight.
        if (reset) begin
            ld_pc      = 1'b0;
            ld_ir      = 1'b0;
            ld_acc     = 1'b0;
            ld_mar     = 1'b0;
            ld_mdr     = 1'b0;
            pc_sel     = 1'b0;
            mar_sel    = 1'b0;
            alu_op     = 3'd0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            halted     = 1'b0;
            illegal_op = 1'b0;
            bus_error  = 1'b0;
            state_dbg  = 3'd0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - scoreboard bench for cpu_ctrl_fsm driven by an instruction-level reference model
module tb_cpu_ctrl_fsm;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic       ld_pc, ld_ir, ld_acc, ld_mar, ld_mdr, pc_sel, mar_sel;
        logic [2:0] alu_op;
        logic       mem_rd, mem_wr, halted, bus_error, illegal_op;
        logic [2:0] state_dbg;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       acc_zero = 1'b0, acc_neg = 1'b0, mem_ready = 1'b0;
    logic       ld_pc, ld_ir, ld_acc, ld_mar, ld_mdr, pc_sel, mar_sel;
    logic [2:0] alu_op;
    logic       mem_rd, mem_wr, halted, bus_error, illegal_op;
    logic [2:0] state_dbg;

    outs_t exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    m_berr = 1'b0;
    bit    m_stop = 1'b0;

    cpu_ctrl_fsm #(.OPW(4), .TIMEOUT(TIMEOUT), .TW(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .acc_zero(acc_zero),
        .acc_neg(acc_neg), .mem_ready(mem_ready), .ld_pc(ld_pc), .ld_ir(ld_ir),
        .ld_acc(ld_acc), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .pc_sel(pc_sel),
        .mar_sel(mar_sel), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .halted(halted), .bus_error(bus_error), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    outs_t mon_act, mon_exp;
    string mon_tag;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = '{ld_pc, ld_ir, ld_acc, ld_mar, ld_mdr, pc_sel, mar_sel, alu_op,
                        mem_rd, mem_wr, halted, bus_error, illegal_op, state_dbg};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL %s @%0t: got %h want %h", mon_tag, $time, mon_act, mon_exp);
            end
        end
    end

    function automatic outs_t blank(input logic [2:0] st);
        outs_t e = '0;
        e.state_dbg = st;
        e.bus_error = m_berr;
        return e;
    endfunction

    task automatic step(input logic rdy, input outs_t e, input string tag);
        mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step(1'($urandom), '0, "reset");
        reset = 1'b0;
        m_berr = 1'b0;
        m_stop = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        outs_t e;
        m_stop = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = blank(3'd5);
            e.halted = 1'b1;
            step(1'($urandom), e, "halt");
        end
    endtask

    // A memory access that completes after w stall cycles, unless the watchdog gives up first.
    task automatic access(input logic [2:0] st, input bit wr, input int w, input bit fetch, output bit ok);
        outs_t e;
        ok = 1'b0;
        for (int k = 0; k < TIMEOUT && !ok; k++) begin
            e = blank(st);
            if (wr) e.mem_wr = 1'b1; else e.mem_rd = 1'b1;
            if (k == w) begin
                if (fetch) begin e.ld_ir = 1'b1; e.ld_pc = 1'b1; end
                else if (!wr) e.ld_mdr = 1'b1;
                step(1'b1, e, fetch ? "fetch_rd_done" : "mem_done");
                ok = 1'b1;
            end else begin
                step(1'b0, e, fetch ? "fetch_rd_wait" : "mem_wait");
            end
        end
        if (!ok) m_berr = 1'b1;
    endtask

    task automatic instr(input logic [3:0] op, input int wf, input int wm);
        outs_t e;
        bit    ok;
        opcode   = op;
        acc_zero = 1'($urandom);
        acc_neg  = 1'($urandom);
        e = blank(3'd0);
        e.ld_mar = 1'b1;
        step(1'($urandom), e, "fetch");
        access(3'd1, 1'b0, wf, 1'b1, ok);
        if (!ok) begin
            halt_cycles(3);
        end else begin
            e = blank(3'd2);
            if (op >= 4'h1 && op <= 4'h5) begin e.mar_sel = 1'b1; e.ld_mar = 1'b1; end
            else if (op == 4'h6) begin e.pc_sel = 1'b1; e.ld_pc = 1'b1; end
            else if (op == 4'h7) begin e.pc_sel = 1'b1; e.ld_pc = acc_zero; end
            else if (op == 4'h8) begin e.pc_sel = 1'b1; e.ld_pc = acc_neg; end
            else if (op >= 4'h9 && op <= 4'hE) e.illegal_op = 1'b1;
            step(1'($urandom), e, "decode");
            if (op == 4'hF) begin
                halt_cycles(4);
            end else if (op >= 4'h1 && op <= 4'h5) begin
                access(3'd3, op == 4'h2, wm, 1'b0, ok);
                if (!ok) begin
                    halt_cycles(3);
                end else if (op != 4'h2) begin
                    e = blank(3'd4);
                    e.ld_acc = 1'b1;
                    e.alu_op = (op == 4'h3) ? 3'd1 : (op == 4'h4) ? 3'd2 : (op == 4'h5) ? 3'd3 : 3'd0;
                    step(1'($urandom), e, "exec");
                end
            end
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
    endfunction

    initial begin
        outs_t e;
        @(posedge clk);
        #1;
        do_reset(2);

        instr(4'h0, 0, 0);
        instr(4'h6, 0, 0);
        instr(4'h3, 0, 3);
        opcode = 4'h7;
        instr(4'h7, 0, 0);
        instr(4'h7, 1, 0);
        instr(4'h2, 0, 1000);
        do_reset(1);
        instr(4'hA, 0, 0);
        instr(4'hF, 0, 0);
        do_reset(1);

        opcode = 4'h1;
        e = blank(3'd0); e.ld_mar = 1'b1;
        step(1'b0, e, "pre_abort_fetch");
        e = blank(3'd1); e.mem_rd = 1'b1;
        step(1'b0, e, "pre_abort_fetch_rd");
        reset = 1'b1;
        step(1'b0, '0, "abort_reset");
        reset = 1'b0;
        instr(4'h1, 0, 0);

        for (int i = 0; i < 200; i++) begin
            instr(4'($urandom), rand_wait(), rand_wait());
            if (m_stop) do_reset(1 + int'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
